fetch_stage: RTL and testbench

- Instruction-fetch stage: owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Feeds the decode stage and the load-use hazard unit.
- Obeys the hazard unit's pc_write / if_id_write stall strobes and the EX-stage branch redirect.
- Inserts NOP bubbles on flush and on memory latency.

---
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory request handshake and IF/ID register.
// Handles hazard-unit stalls, EX-stage redirects and bubbles while memory is slow.
module fetch_stage #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_write,
    input  logic            if_id_write,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic            if_id_valid
);

    // S_HOLD parks a returned word while the pipeline is stalled;
    // S_DROP waits out a request whose address was redirected away.
    typedef enum logic [1:0] {
        S_REQ,
        S_HOLD,
        S_DROP
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     fetch_buf;

    logic            adv;
    logic            deliver;
    logic            bubble;
    logic [31:0]     deliver_instr;

    assign adv       = pc_write & if_id_write;
    assign imem_req  = !reset && (state != S_HOLD);
    assign imem_addr = pc;
    assign pc_out    = pc;

    // IF/ID load decode: a real instruction, a bubble, or hold.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        deliver       = 1'b0;
        bubble        = 1'b0;
        deliver_instr = imem_rdata;
        case (state)
            S_REQ: begin
                if (branch_taken)
                    bubble = 1'b1;
                else if (imem_ready && adv)
                    deliver = 1'b1;
                else if (!imem_ready && if_id_write)
                    bubble = 1'b1;
            end
            S_HOLD: begin
                deliver_instr = fetch_buf;
                if (branch_taken)
                    bubble = 1'b1;
                else if (adv)
                    deliver = 1'b1;
            end
            S_DROP: begin
                bubble = branch_taken | if_id_write;
            end
            default: begin
                bubble = 1'b1;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            redirect_pc <= '0;
            fetch_buf   <= '0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else begin
            if (deliver) begin
                if_id_pc    <= pc;
                if_id_instr <= deliver_instr;
                if_id_valid <= 1'b1;
            end else if (bubble) begin
                if_id_pc    <= '0;
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
            end

            case (state)
                S_REQ: begin
                    if (branch_taken) begin
                        if (imem_ready) begin
                            pc <= branch_target;
                        end else begin
                            redirect_pc <= branch_target;
                            state       <= S_DROP;
                        end
                    end else if (imem_ready) begin
                        if (adv) begin
                            pc <= pc + XLEN'(4);
                        end else begin
                            fetch_buf <= imem_rdata;
                            state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (branch_taken) begin
                        pc    <= branch_target;
                        state <= S_REQ;
                    end else if (adv) begin
                        pc    <= pc + XLEN'(4);
                        state <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (branch_taken)
                        redirect_pc <= branch_target;
                    if (imem_ready) begin
                        pc    <= branch_taken ? branch_target : redirect_pc;
                        state <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized traffic,
// all compared against a transaction-level model of the fetch stage.
module tb_fetch_stage;

    localparam int          XLEN      = 64;
    localparam logic [63:0] RESET_PC  = 64'h0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            reset;
    logic            pc_write;
    logic            if_id_write;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            imem_ready;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] if_id_pc;
    logic [31:0]     if_id_instr;
    logic            if_id_valid;

    int errors = 0;
    int checks = 0;

    // Model: fetch address, IF/ID contents, a parked instruction word (if any)
    // and a pending redirect target (if the in-flight request must be dropped).
    logic [63:0] m_pc;
    logic [63:0] m_ifid_pc;
    logic [31:0] m_ifid_instr;
    logic        m_ifid_valid;
    logic [31:0] held_q[$];
    logic [63:0] redir_q[$];

    fetch_stage #(
        .XLEN(XLEN),
        .RESET_PC(RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pc_write(pc_write),
        .if_id_write(if_id_write),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .pc_out(pc_out),
        .if_id_pc(if_id_pc),
        .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] addr);
        return (addr[31:0] * 32'h9E37_79B1) ^ addr[63:32] ^ 32'h5A5A_0001;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_bubble();
        m_ifid_pc    = 64'h0;
        m_ifid_instr = NOP_INSTR;
        m_ifid_valid = 1'b0;
    endtask

    task automatic model_deliver(input logic [31:0] word);
        m_ifid_pc    = m_pc;
        m_ifid_instr = word;
        m_ifid_valid = 1'b1;
        m_pc         = m_pc + 64'd4;
    endtask

    task automatic check_regs();
        check("pc_out", pc_out, m_pc);
        check("if_id_valid", 64'(if_id_valid), 64'(m_ifid_valid));
        check("if_id_pc", if_id_pc, m_ifid_pc);
        check("if_id_instr", 64'(if_id_instr), 64'(m_ifid_instr));
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic do_reset();
        reset         = 1'b1;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 64'h0;
        imem_ready    = 1'b1;
        imem_rdata    = 32'hDEAD_BEEF;
        #1;
        check("req_in_reset", 64'(imem_req), 64'h0);
        @(posedge clk);
        #1;
        m_pc = RESET_PC;
        model_bubble();
        held_q.delete();
        redir_q.delete();
        check_regs();
        reset = 1'b0;
    endtask

    task automatic step(input logic pw, input logic iw, input logic br,
                        input logic [63:0] tgt, input logic rdy);
        logic [31:0] word;
        logic        adv_m;
        word          = mem_word(m_pc);
        pc_write      = pw;
        if_id_write   = iw;
        branch_taken  = br;
        branch_target = tgt;
        imem_ready    = rdy;
        imem_rdata    = word;
        adv_m         = pw & iw;
        #1;
        check("imem_req", 64'(imem_req), 64'(held_q.size() == 0));
        if (held_q.size() == 0)
            check("imem_addr", imem_addr, m_pc);

        if (redir_q.size() != 0) begin
            if (br) redir_q[0] = tgt;
            if (rdy) m_pc = redir_q.pop_front();
            if (br || iw) model_bubble();
        end else if (held_q.size() != 0) begin
            if (br) begin
                held_q.delete();
                m_pc = tgt;
                model_bubble();
            end else if (adv_m) begin
                model_deliver(held_q.pop_front());
            end
        end else begin
            if (br) begin
                if (rdy) m_pc = tgt;
                else redir_q.push_back(tgt);
                model_bubble();
            end else if (rdy && adv_m) begin
                model_deliver(word);
            end else if (rdy) begin
                held_q.push_back(word);
            end else if (iw) begin
                model_bubble();
            end
        end

        @(posedge clk);
        #1;
        check_regs();
    endtask

    initial begin
        logic [31:0] r;
        logic [63:0] tgt;
        logic        stall;

        reset         = 1'b1;
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 64'h0;
        imem_ready    = 1'b0;
        imem_rdata    = 32'h0;
        @(posedge clk);
        #1;
        do_reset();

        // Streaming: one instruction per cycle.
        for (int i = 0; i < 4; i++) begin
            check("stream_addr", imem_addr, 64'(i * 4));
            step(1'b1, 1'b1, 1'b0, 64'h0, 1'b1);
            check("stream_ifid_pc", if_id_pc, 64'(i * 4));
            check("stream_valid", 64'(if_id_valid), 64'h1);
        end

        // Load-use stall at PC 8, then release.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 64'h0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 64'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        check("stall_pc", pc_out, 64'h8);
        check("stall_ifid_pc", if_id_pc, 64'h4);
        check("stall_req", 64'(imem_req), 64'h0);
        step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
        check("release_ifid_pc", if_id_pc, 64'h8);
        check("release_addr", imem_addr, 64'hC);

        // Flush while stalled.
        step(1'b0, 1'b0, 1'b1, 64'h100, 1'b1);
        check("flush_valid", 64'(if_id_valid), 64'h0);
        check("flush_instr", 64'(if_id_instr), 64'h13);
        check("flush_addr", imem_addr, 64'h100);

        // Redirect while the request at 0x20 is still outstanding.
        step(1'b1, 1'b1, 1'b1, 64'h20, 1'b1);
        step(1'b1, 1'b1, 1'b1, 64'h200, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
            check("drop_addr", imem_addr, 64'h20);
            check("drop_valid", 64'(if_id_valid), 64'h0);
        end
        step(1'b1, 1'b1, 1'b0, 64'h0, 1'b1);
        check("drop_done_valid", 64'(if_id_valid), 64'h0);
        check("drop_done_addr", imem_addr, 64'h200);
        check("drop_done_req", 64'(imem_req), 64'h1);

        // Two redirects before the dropped request completes.
        step(1'b1, 1'b1, 1'b1, 64'h200, 1'b0);
        step(1'b1, 1'b1, 1'b1, 64'h300, 1'b0);
        step(1'b1, 1'b1, 1'b0, 64'h0, 1'b1);
        check("double_redirect_pc", pc_out, 64'h300);

        // PC wrap.
        step(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        step(1'b1, 1'b1, 1'b0, 64'h0, 1'b1);
        check("wrap_pc", pc_out, 64'h0);
        check("wrap_ifid_pc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);

        // Reset while holding a parked word.
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        check("hold_req", 64'(imem_req), 64'h0);
        do_reset();
        check("post_reset_pc", pc_out, RESET_PC);
        check("post_reset_valid", 64'(if_id_valid), 64'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            if (r[5:0] == 6'd0) begin
                do_reset();
            end else begin
                stall = (r[7:6] == 2'b00);
                tgt   = {$urandom, $urandom};
                if (r[8]) tgt[1:0] = 2'b00;
                step(!stall, !stall, r[11:9] == 3'b000, tgt, r[12] | r[13]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
